trap_irq_ctrl: RTL and testbench
================================

// Module: trap_irq_ctrl
// PURPOSE
//  Parametrised trap/interrupt controller for the Mini-RISC-V core.
//  Merges ecall and NUM_IRQ external interrupt lines into one trap request.
//  Drives the fetch-stage handshake (trapping, trigger_trap, trigger_trap_ret) and supplies mcause and the trap target PC.
//  Adds per-source enables, edge/level capture, fixed priority, vectored targets and stall awareness.
// PARAMETERS
//  NUM_IRQ    4                   number of external interrupt sources (1..16)
//  XLEN       32                  datapath / CSR width
//  EDGE_MASK  {NUM_IRQ{1'b0}}     bit i = 1: source i is rising-edge captured; bit i = 0: source i is level
//  VECTORED   1                   1: interrupt target = base + 4*cause_code; 0: all traps go to base
// PORTS
//  clk               in   1        system clock
//  Rst               in   1        reset, synchronous, active-high
//  mem_hold          in   1        pipeline stall; freezes the FSM
//  irq               in   NUM_IRQ  raw interrupt lines
//  irq_en            in   NUM_IRQ  per-source enable (mie)
//  mie_global        in   1        global interrupt enable (mstatus.MIE)
//  ecall             in   1        ecall decoded in ID
//  trap_ret          in   1        mret decoded in ID
//  mtvec             in   XLEN     trap vector CSR; bits[1:0] ignored
//  trapping          out  1        high while a handler is active
//  trigger_trap      out  1        trap-entry strobe to fetch
//  trigger_trap_ret  out  1        trap-return strobe to fetch
//  trap_target       out  XLEN     PC fetch loads on trigger_trap
//  mcause            out  XLEN     [XLEN-1] = interrupt flag; low bits = cause code
//  irq_pending       out  NUM_IRQ  mip view: pending & enabled
//  irq_ack           out  NUM_IRQ  one-hot acknowledge to the taken source
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0; edge-pending bits are 0; irq_q <= irq while Rst is high, so a line already high at release is not an edge.
//  Pending: edge source: set on irq & ~irq_q, cleared by its irq_ack; set wins if both occur in the same cycle.
//    Level source: pending = irq (live).
//  eligible = pending & irq_en & {NUM_IRQ{mie_global}}.
//  Priority: ecall > lowest-index eligible IRQ.
//  Cause codes: ecall -> mcause = 11 with interrupt bit 0. IRQ i -> mcause = 16+i with interrupt bit 1.
//  Target: base = {mtvec[XLEN-1:2], 2'b00}.
//    ecall -> base.
//    IRQ with VECTORED=1 -> base + 4*(16+i), mod 2^XLEN.
//    IRQ with VECTORED=0 -> base.
//  mcause and trap_target are registered when the trap is taken and held until the next trap.
//  FSM states: IDLE, ENTER, TRAP, EXIT.
//   IDLE : mem_hold=0 and (ecall or |eligible) -> ENTER. Latch mcause and target; pulse irq_ack[i] for one cycle if an IRQ won.
//          mem_hold=1 -> remain in IDLE; the request is re-evaluated next cycle.
//   ENTER: trigger_trap=1, trapping=1. Hold while mem_hold=1 (strobe stays high); mem_hold=0 -> TRAP.
//   TRAP : trapping=1. trap_ret and mem_hold=0 -> EXIT.
//          ecall is ignored and lost; IRQs stay pending (no nesting).
//   EXIT : trigger_trap_ret=1, trapping=0. Hold while mem_hold=1; mem_hold=0 -> IDLE.
//          Requests are not sampled in EXIT; they are evaluated in the next IDLE cycle.
//  Latency: request sampled in cycle N (IDLE, no hold) -> trigger_trap and trapping high in N+1.
//    trap_ret sampled in cycle M (TRAP) -> trigger_trap_ret in M+1.
//  trap_ret while in IDLE is ignored. Rst mid-handler -> IDLE next edge with all outputs 0.
// TESTING
//  NUM_IRQ=4, VECTORED=1, mtvec=0x100: ecall pulse in IDLE -> next cycle trigger_trap=1, mcause=11, trap_target=0x100.
//  irq=4'b0110, irq_en=4'hF, mie_global=1 -> irq 1 wins: irq_ack=4'b0010, mcause=0x80000011, trap_target=0x144.
//  ecall and irq[0] in the same cycle -> mcause=11, irq_ack=0, irq[0] still pending; taken after trap_ret and EXIT.
//  Edge source 2: one-cycle pulse while in TRAP -> irq_pending[2]=1; taken on the first IDLE cycle after EXIT.
//  mem_hold=1 for 3 cycles during ENTER -> trigger_trap stays high for 4 cycles, then TRAP.
//  Rst during TRAP -> trapping=0 and mcause=0 next cycle; irq held high through reset release -> no edge capture.

Source files
------------

// File: rtl/trap_irq_ctrl.sv
// Trap/interrupt controller: merges ecall and NUM_IRQ external lines into one
// trap request and drives the fetch-stage trap entry/return handshake.
module trap_irq_ctrl #(
  parameter int                 NUM_IRQ   = 4,
  parameter int                 XLEN      = 32,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter bit                 VECTORED  = 1'b1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               mem_hold,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie_global,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic [XLEN-1:0]    mtvec,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [XLEN-1:0]    trap_target,
  output logic [XLEN-1:0]    mcause,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_ack
);

  typedef enum logic [1:0] {IDLE, ENTER, TRAP, EXIT} state_t;

  state_t             state_reg;
  logic [NUM_IRQ-1:0] irq_q_reg;
  logic [NUM_IRQ-1:0] edge_pend_reg;
  logic [NUM_IRQ-1:0] irq_pending_reg;
  logic [NUM_IRQ-1:0] irq_ack_reg;
  logic               trapping_reg;
  logic               trigger_trap_reg;
  logic               trigger_trap_ret_reg;
  logic [XLEN-1:0]    mcause_reg;
  logic [XLEN-1:0]    trap_target_reg;

  logic [NUM_IRQ-1:0] edge_rise;
  logic [NUM_IRQ-1:0] edge_pend_next;
  logic [NUM_IRQ-1:0] pending_cur;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_onehot;
  logic               win_found;
  logic [3:0]         win_idx;
  logic [4:0]         irq_code;
  logic [XLEN-1:0]    base;
  logic [XLEN-1:0]    irq_mcause;
  logic [XLEN-1:0]    irq_target;

  // A new edge in the same cycle as its acknowledge keeps the bit pending.
  assign edge_rise      = irq & ~irq_q_reg & EDGE_MASK;
  assign edge_pend_next = (edge_pend_reg & ~irq_ack_reg) | edge_rise;
  assign pending_cur    = edge_pend_reg | (irq & ~EDGE_MASK);
  assign eligible       = pending_cur & irq_en & {NUM_IRQ{mie_global}};

  // Scan from the top so the lowest-index eligible source wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_found = 1'b1;
        win_idx   = 4'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_onehot
      assign win_onehot[gi] = win_found && (win_idx == 4'(gi));
    end
  endgenerate

  // Cause code of IRQ i is 16+i, i.e. a 1 prepended to the 4-bit index.
  assign irq_code   = {1'b1, win_idx};
  assign base       = mtvec & {{(XLEN-2){1'b1}}, 2'b00};
  assign irq_mcause = {1'b1, {(XLEN-6){1'b0}}, irq_code};

  generate
    if (VECTORED) begin : g_vec
      assign irq_target = base + {{(XLEN-7){1'b0}}, irq_code, 2'b00};
    end else begin : g_flat
      assign irq_target = base;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg            <= IDLE;
      irq_q_reg            <= irq;
      edge_pend_reg        <= '0;
      irq_pending_reg      <= '0;
      irq_ack_reg          <= '0;
      trapping_reg         <= 1'b0;
      trigger_trap_reg     <= 1'b0;
      trigger_trap_ret_reg <= 1'b0;
      mcause_reg           <= '0;
      trap_target_reg      <= '0;
    end else begin
      irq_q_reg       <= irq;
      edge_pend_reg   <= edge_pend_next;
      irq_pending_reg <= (edge_pend_next | (irq & ~EDGE_MASK)) & irq_en;
      irq_ack_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (!mem_hold && (ecall || win_found)) begin
            state_reg        <= ENTER;
            trapping_reg     <= 1'b1;
            trigger_trap_reg <= 1'b1;
            if (ecall) begin
              mcause_reg      <= XLEN'(11);
              trap_target_reg <= base;
            end else begin
              mcause_reg      <= irq_mcause;
              trap_target_reg <= irq_target;
              irq_ack_reg     <= win_onehot;
            end
          end
        end
        ENTER: begin
          if (!mem_hold) begin
            state_reg        <= TRAP;
            trigger_trap_reg <= 1'b0;
          end
        end
        TRAP: begin
          if (trap_ret && !mem_hold) begin
            state_reg            <= EXIT;
            trapping_reg         <= 1'b0;
            trigger_trap_ret_reg <= 1'b1;
          end
        end
        EXIT: begin
          if (!mem_hold) begin
            state_reg            <= IDLE;
            trigger_trap_ret_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign trapping         = trapping_reg;
  assign trigger_trap     = trigger_trap_reg;
  assign trigger_trap_ret = trigger_trap_ret_reg;
  assign mcause           = mcause_reg;
  assign trap_target      = trap_target_reg;
  assign irq_pending      = irq_pending_reg;
  assign irq_ack          = irq_ack_reg;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Directed bench for trap_irq_ctrl: a cycle-by-cycle vector table followed by
// hand sequences for stall during entry, edge capture in TRAP and reset.
module tb_trap_irq_ctrl;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mem_hold = 1'b0;
  logic [3:0]  irq = 4'h0;
  logic [3:0]  irq_en = 4'hF;
  logic        mie_global = 1'b1;
  logic        ecall = 1'b0;
  logic        trap_ret = 1'b0;
  logic [31:0] mtvec = 32'h0000_0100;
  logic        trapping;
  logic        trigger_trap;
  logic        trigger_trap_ret;
  logic [31:0] trap_target;
  logic [31:0] mcause;
  logic [3:0]  irq_pending;
  logic [3:0]  irq_ack;

  int errors = 0;
  int checks = 0;

  trap_irq_ctrl #(
    .NUM_IRQ  (4),
    .XLEN     (32),
    .EDGE_MASK(4'b0100),
    .VECTORED (1'b1)
  ) dut (
    .clk             (clk),
    .Rst             (Rst),
    .mem_hold        (mem_hold),
    .irq             (irq),
    .irq_en          (irq_en),
    .mie_global      (mie_global),
    .ecall           (ecall),
    .trap_ret        (trap_ret),
    .mtvec           (mtvec),
    .trapping        (trapping),
    .trigger_trap    (trigger_trap),
    .trigger_trap_ret(trigger_trap_ret),
    .trap_target     (trap_target),
    .mcause          (mcause),
    .irq_pending     (irq_pending),
    .irq_ack         (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        t;
    logic        tt;
    logic        tr;
    logic [31:0] mc;
    logic [31:0] tg;
    logic [3:0]  ack;
    logic [3:0]  pend;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       ec;
    logic       ret;
    logic       hold;
    logic [3:0] irq_v;
    logic [3:0] en_v;
    logic       mie_v;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] C_EC = 32'd11;
  localparam logic [31:0] C_I0 = 32'h8000_0010;
  localparam logic [31:0] C_I1 = 32'h8000_0011;
  localparam logic [31:0] C_I2 = 32'h8000_0012;
  localparam logic [31:0] C_I3 = 32'h8000_0013;

  function automatic outs_t mk(input logic t, tt, tr, input logic [31:0] mc, tg,
                               input logic [3:0] ack, pend);
    outs_t o;
    o.t = t; o.tt = tt; o.tr = tr; o.mc = mc; o.tg = tg; o.ack = ack; o.pend = pend;
    return o;
  endfunction

  task automatic add(input logic rst, ec, ret, hold, input logic [3:0] irq_v, en_v,
                     input logic mie_v, input outs_t exp);
    vec_t v;
    v.rst = rst; v.ec = ec; v.ret = ret; v.hold = hold;
    v.irq_v = irq_v; v.en_v = en_v; v.mie_v = mie_v; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm);
    outs_t act;
    act = {trapping, trigger_trap, trigger_trap_ret, mcause, trap_target, irq_ack, irq_pending};
    checks++;
    $display("check %s: t=%0b tt=%0b tr=%0b mcause=%h target=%h ack=%b pend=%b",
             nm, act.t, act.tt, act.tr, act.mc, act.tg, act.ack, act.pend);
    if (act !== exp_cur) begin
      errors++;
      $display("FAIL %s: got t=%0b tt=%0b tr=%0b mcause=%h target=%h ack=%b pend=%b, expected t=%0b tt=%0b tr=%0b mcause=%h target=%h ack=%b pend=%b",
               nm, act.t, act.tt, act.tr, act.mc, act.tg, act.ack, act.pend,
               exp_cur.t, exp_cur.tt, exp_cur.tr, exp_cur.mc, exp_cur.tg, exp_cur.ack, exp_cur.pend);
    end
  endtask

  outs_t exp_cur;

  task automatic step_chk(input string nm, input outs_t e);
    tick();
    exp_cur = e;
    check(nm);
  endtask

  initial begin
    // rst ec ret hold irq en mie | expected after the following edge
    add(1,0,0,0,4'h0,4'hF,1, mk(0,0,0,32'h0, 32'h0,  4'h0,4'h0)); // reset
    add(0,1,0,0,4'h0,4'hF,1, mk(1,1,0,C_EC,32'h100,4'h0,4'h0)); // ecall taken
    add(0,0,0,0,4'h0,4'hF,1, mk(1,0,0,C_EC,32'h100,4'h0,4'h0)); // -> TRAP
    add(0,1,0,0,4'h0,4'hF,1, mk(1,0,0,C_EC,32'h100,4'h0,4'h0)); // ecall lost in TRAP
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,1,C_EC,32'h100,4'h0,4'h0)); // mret -> EXIT
    add(0,0,0,0,4'h0,4'hF,1, mk(0,0,0,C_EC,32'h100,4'h0,4'h0)); // -> IDLE, cause held
    add(0,0,0,0,4'h6,4'hF,1, mk(1,1,0,C_I1,32'h144,4'h2,4'h6)); // irq1 wins, irq2 edge latched
    add(0,0,0,0,4'h0,4'hF,1, mk(1,0,0,C_I1,32'h144,4'h0,4'h4));
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,1,C_I1,32'h144,4'h0,4'h4));
    add(0,0,0,0,4'h0,4'hF,1, mk(0,0,0,C_I1,32'h144,4'h0,4'h4)); // EXIT does not sample
    add(0,0,0,0,4'h0,4'hF,1, mk(1,1,0,C_I2,32'h148,4'h4,4'h4)); // pending edge taken
    add(0,0,0,0,4'h0,4'hF,1, mk(1,0,0,C_I2,32'h148,4'h0,4'h0)); // ack cleared edge bit
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,1,C_I2,32'h148,4'h0,4'h0));
    add(0,0,0,0,4'h0,4'hF,1, mk(0,0,0,C_I2,32'h148,4'h0,4'h0));
    add(0,1,0,0,4'h1,4'hF,1, mk(1,1,0,C_EC,32'h100,4'h0,4'h1)); // ecall beats irq0
    add(0,0,0,0,4'h1,4'hF,1, mk(1,0,0,C_EC,32'h100,4'h0,4'h1));
    add(0,0,1,0,4'h1,4'hF,1, mk(0,0,1,C_EC,32'h100,4'h0,4'h1));
    add(0,0,0,0,4'h1,4'hF,1, mk(0,0,0,C_EC,32'h100,4'h0,4'h1));
    add(0,0,0,0,4'h1,4'hF,1, mk(1,1,0,C_I0,32'h140,4'h1,4'h1)); // irq0 after EXIT
    add(0,0,0,0,4'h0,4'hF,1, mk(1,0,0,C_I0,32'h140,4'h0,4'h0));
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,1,C_I0,32'h140,4'h0,4'h0));
    add(0,0,0,0,4'h0,4'hF,1, mk(0,0,0,C_I0,32'h140,4'h0,4'h0));
    add(0,0,0,0,4'h8,4'hF,0, mk(0,0,0,C_I0,32'h140,4'h0,4'h8)); // global disable
    add(0,0,0,0,4'h8,4'h7,1, mk(0,0,0,C_I0,32'h140,4'h0,4'h0)); // source disabled
    add(0,0,0,1,4'h8,4'hF,1, mk(0,0,0,C_I0,32'h140,4'h0,4'h8)); // stalled in IDLE
    add(0,0,0,0,4'h8,4'hF,1, mk(1,1,0,C_I3,32'h14C,4'h8,4'h8)); // irq3 taken
    add(0,0,0,0,4'h0,4'hF,1, mk(1,0,0,C_I3,32'h14C,4'h0,4'h0));
    add(0,0,1,1,4'h0,4'hF,1, mk(1,0,0,C_I3,32'h14C,4'h0,4'h0)); // mret stalled
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,1,C_I3,32'h14C,4'h0,4'h0));
    add(0,0,0,1,4'h0,4'hF,1, mk(0,0,1,C_I3,32'h14C,4'h0,4'h0)); // EXIT held
    add(0,0,0,0,4'h0,4'hF,1, mk(0,0,0,C_I3,32'h14C,4'h0,4'h0));
    add(0,0,1,0,4'h0,4'hF,1, mk(0,0,0,C_I3,32'h14C,4'h0,4'h0)); // mret in IDLE ignored

    foreach (vecs[i]) begin
      Rst = vecs[i].rst; ecall = vecs[i].ec; trap_ret = vecs[i].ret;
      mem_hold = vecs[i].hold; irq = vecs[i].irq_v; irq_en = vecs[i].en_v;
      mie_global = vecs[i].mie_v;
      step_chk($sformatf("vec%0d", i), vecs[i].exp);
    end
    ecall = 0; trap_ret = 0; mem_hold = 0; irq = 4'h0; irq_en = 4'hF; mie_global = 1;

    // Stall during ENTER keeps the strobe up, then an edge pulse arrives in TRAP.
    ecall = 1;
    step_chk("hold_enter0", mk(1,1,0,C_EC,32'h100,4'h0,4'h0));
    ecall = 0; mem_hold = 1;
    for (int k = 1; k <= 3; k++)
      step_chk($sformatf("hold_enter%0d", k), mk(1,1,0,C_EC,32'h100,4'h0,4'h0));
    mem_hold = 0;
    step_chk("hold_release", mk(1,0,0,C_EC,32'h100,4'h0,4'h0));
    irq = 4'h4;
    step_chk("pulse_in_trap", mk(1,0,0,C_EC,32'h100,4'h0,4'h4));
    irq = 4'h0;
    step_chk("pulse_held", mk(1,0,0,C_EC,32'h100,4'h0,4'h4));
    trap_ret = 1;
    step_chk("pulse_exit", mk(0,0,1,C_EC,32'h100,4'h0,4'h4));
    trap_ret = 0;
    step_chk("pulse_idle", mk(0,0,0,C_EC,32'h100,4'h0,4'h4));
    step_chk("pulse_taken", mk(1,1,0,C_I2,32'h148,4'h4,4'h4));
    step_chk("pulse_trap", mk(1,0,0,C_I2,32'h148,4'h0,4'h0));

    // Reset mid-handler with the edge line held high across release.
    Rst = 1; irq = 4'h4;
    step_chk("rst_in_trap", mk(0,0,0,32'h0,32'h0,4'h0,4'h0));
    Rst = 0;
    step_chk("rst_release", mk(0,0,0,32'h0,32'h0,4'h0,4'h0));
    step_chk("no_edge", mk(0,0,0,32'h0,32'h0,4'h0,4'h0));
    irq = 4'h0;
    step_chk("line_low", mk(0,0,0,32'h0,32'h0,4'h0,4'h0));
    irq = 4'h4;
    step_chk("new_edge", mk(0,0,0,32'h0,32'h0,4'h0,4'h4));
    step_chk("new_edge_taken", mk(1,1,0,C_I2,32'h148,4'h4,4'h4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
